// File: rtl/bk_add_pkg.sv
// rtl/bk_add_pkg.sv - shared widths, types and bus helper for the Brent-Kung adder stream wrapper
//
// Purpose: operand/sum widths, typedefs and the operand interleaving function
// used to drive the 12-bit combinational Brent-Kung adder.
// Ports: none (package).
package bk_add_pkg;

  localparam int ADD_W = 12;
  localparam int SUM_W = 13;

  typedef logic [ADD_W-1:0] opnd_t;
  typedef logic [SUM_W-1:0] sum_t;

  // Adder bus layout: bit 2i = a[i], bit 2i+1 = b[i].
  function automatic logic [2*ADD_W-1:0] interleave(input opnd_t a, input opnd_t b);
    logic [2*ADD_W-1:0] bus;
    bus = '0;
    for (int i = 0; i < ADD_W; i++) begin
      bus[2*i]   = a[i];
      bus[2*i+1] = b[i];
    end
    return bus;
  endfunction

endpackage

// File: rtl/bk_out_fifo.sv
// rtl/bk_out_fifo.sv - synchronous result FIFO with a registered head
//
// Purpose: DEPTH-entry FIFO. The head (rd_valid/rd_data) is a register that
// holds its last value when the FIFO drains, so downstream sees no
// combinational path from the storage array.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write strobe and data (ignored when full without a pop)
//   pop              consume head (only effective while rd_valid)
//   rd_valid         head valid
//   rd_data          head data, reset to 0
//   count            number of stored entries
module bk_out_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bk_out_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [PTR_W:0]   count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             full, do_push, do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign do_pop    = pop & rd_valid;
  assign do_push   = push & (~full | do_pop);
  assign count_nxt = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  assign rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  // Next head: the incoming word becomes head when it lands in the slot
  // that the read pointer is about to point at.
  always_comb begin
    head_nxt = rd_data;
    if (count_nxt != '0) begin
      if (do_push && (rd_ptr_nxt == wr_ptr)) head_nxt = push_data;
      else                                   head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      rd_data  <= head_nxt;
    end
  end

endmodule

// File: rtl/bk_add_stream_ctrl.sv
// rtl/bk_add_stream_ctrl.sv - stream front/back end for the 12-bit Brent-Kung adder
//
// Purpose: registers operand pairs from a valid/ready stream, drives the
// adder's interleaved operand bus, captures the sum into an output FIFO and
// maintains an accumulator (accumulate mode replaces operand B with acc_q).
// Optional feature macro: BK_ADD_SAT_EN (saturate on carry-out).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand stream handshake
//   in_a, in_b, in_acc         operands; in_acc=1 uses acc_q instead of in_b
//   clear                      synchronous clear of acc_q and out_ovf
//   adder_ops                  to adder, bit 2i = A[i], bit 2i+1 = B[i]
//   adder_sum                  from adder, bit 12 = carry-out
//   out_valid/out_ready        result stream handshake
//   out_sum                    FIFO head sum
//   out_ovf                    sticky carry-out of any captured result
module bk_add_stream_ctrl #(
  parameter int ADD_W     = 12,
  parameter int OUT_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADD_W-1:0]   in_a,
  input  logic [ADD_W-1:0]   in_b,
  input  logic               in_acc,
  input  logic               clear,
  output logic [2*ADD_W-1:0] adder_ops,
  input  logic [ADD_W:0]     adder_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADD_W:0]     out_sum,
  output logic               out_ovf
);

  import bk_add_pkg::*;

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  if (ADD_W != bk_add_pkg::ADD_W) begin : g_bad_width
    $error("bk_add_stream_ctrl: ADD_W must equal the adder width (12)");
  end

  logic             op_v, op_acc;
  opnd_t            op_a, op_b, opb_eff, acc_q, acc_nxt;
  sum_t             push_data;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_space, in_fire, capture, pop;

  // Space is judged from the registered count only, so out_ready never
  // reaches in_ready combinationally.
  assign fifo_space = (fifo_count < CNT_W'(OUT_DEPTH));
  assign in_ready   = ~op_v | fifo_space;
  assign in_fire    = in_valid & in_ready;
  assign capture    = op_v & fifo_space;
  assign pop        = out_valid & out_ready;

  // acc_q is read live, so an accumulate op directly behind another sees
  // the result captured on the edge that loaded it.
  assign opb_eff   = op_acc ? acc_q : op_b;
  assign adder_ops = interleave(op_a, opb_eff);

  always_comb begin
`ifdef BK_ADD_SAT_EN
    if (adder_sum[ADD_W]) begin
      push_data = sum_t'({1'b0, {ADD_W{1'b1}}});
      acc_nxt   = '1;
    end else begin
      push_data = adder_sum;
      acc_nxt   = adder_sum[ADD_W-1:0];
    end
`else
    push_data = adder_sum;
    acc_nxt   = adder_sum[ADD_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_v   <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_acc <= 1'b0;
    end else if (in_fire) begin
      op_v   <= 1'b1;
      op_a   <= in_a;
      op_b   <= in_b;
      op_acc <= in_acc;
    end else if (capture) begin
      // Freeze the B value actually used so adder_ops stays put while the
      // op register sits empty, even though acc_q moves on this edge.
      op_v   <= 1'b0;
      op_b   <= opb_eff;
      op_acc <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      out_ovf <= 1'b0;
    end else if (clear) begin
      acc_q   <= '0;
      out_ovf <= 1'b0;
    end else if (capture) begin
      acc_q   <= acc_nxt;
      out_ovf <= out_ovf | adder_sum[ADD_W];
    end
  end

  bk_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (ADD_W + 1)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (push_data),
    .pop       (pop),
    .rd_valid  (out_valid),
    .rd_data   (out_sum),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_bk_add_stream_ctrl.sv
// tb/tb_bk_add_stream_ctrl.sv - self-checking bench for bk_add_stream_ctrl
module tb_bk_add_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_acc, clear;
  logic [11:0] in_a, in_b;
  logic [23:0] adder_ops;
  logic [12:0] adder_sum;
  logic        out_valid, out_ready, out_ovf;
  logic [12:0] out_sum;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];
  int          pop_cyc[$];
  logic [11:0] m_acc = '0;
  logic        m_ovf = 1'b0;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bk_add_stream_ctrl #(.ADD_W(12), .OUT_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_acc    (in_acc),
    .clear     (clear),
    .adder_ops (adder_ops),
    .adder_sum (adder_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  // Behavioural stand-in for the combinational adder.
  logic [11:0] ad_a, ad_b;
  always_comb begin
    ad_a = '0;
    ad_b = '0;
    for (int i = 0; i < 12; i++) begin
      ad_a[i] = adder_ops[2*i];
      ad_b[i] = adder_ops[2*i+1];
    end
  end
  assign adder_sum = {1'b0, ad_a} + {1'b0, ad_b};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ref_result(input logic [12:0] raw);
`ifdef BK_ADD_SAT_EN
    return raw[12] ? 13'h0FFF : raw;
`else
    return raw;
`endif
  endfunction

  // Reference model: every accepted pair yields one result, in order; the
  // accumulator follows the result stream.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (in_valid && in_ready) begin
        logic [12:0] raw, r;
        raw = {1'b0, in_a} + {1'b0, (in_acc ? m_acc : in_b)};
        r = ref_result(raw);
        exp_q.push_back(r);
        m_acc = r[11:0];
        m_ovf = m_ovf | raw[12];
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_sum);
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else                   chk("out_sum", out_sum, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic acc);
    int n = 0;
    in_a = a; in_b = b; in_acc = acc; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  logic [12:0] e_ovf_add, e_acc3, e_accrd, e_clr, e_accafter;

  initial begin
`ifdef BK_ADD_SAT_EN
    e_ovf_add = 13'h0FFF; e_acc3 = 13'h0FFF; e_accrd = 13'h0FFF; e_clr = 13'h0FFF;
`else
    e_ovf_add = 13'h1000; e_acc3 = 13'h1000; e_accrd = 13'h0000; e_clr = 13'h1234;
`endif
    e_accafter = 13'h0000;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_acc = 1'b0;
    clear = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_adder_ops", adder_ops, 0);
    chk("rst_in_ready", in_ready, 1);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Interleave and plain add
    got_q.delete();
    send(12'hFFF, 12'h000, 1'b0);
    @(negedge clk);
    chk("interleave", adder_ops, 24'h555555);
    drain();
    chk("add_fff_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("add_fff", got_q[$], 13'h0FFF);
    chk("add_fff_ovf", out_ovf, 0);
    send(12'h800, 12'h800, 1'b0);
    drain();
    if (got_q.size() > 0) chk("add_800", got_q[$], e_ovf_add);
    chk("add_800_ovf", out_ovf, 1);

    // Back-to-back accumulate
    pulse_clear();
    m_acc = '0; m_ovf = 1'b0;
    @(negedge clk);
    chk("clear_ovf", out_ovf, 0);
    @(posedge clk); #1;
    got_q.delete();
    send(12'h005, 12'h000, 1'b0);
    send(12'h003, 12'hABC, 1'b1);
    send(12'hFF8, 12'h123, 1'b1);
    drain();
    chk("acc_cnt", got_q.size(), 3);
    if (got_q.size() >= 3) begin
      chk("acc_0", got_q[0], 13'h005);
      chk("acc_1", got_q[1], 13'h008);
      chk("acc_2", got_q[2], e_acc3);
    end
    chk("acc_ovf", out_ovf, 1);
    send(12'h000, 12'h555, 1'b1);
    drain();
    if (got_q.size() > 0) chk("acc_readback", got_q[$], e_accrd);

    // Backpressure: four pairs with the consumer stalled
    got_q.delete(); pop_cyc.delete();
    out_ready = 1'b0;
    send(12'h010, 12'h001, 1'b0);
    send(12'h020, 12'h002, 1'b0);
    send(12'h030, 12'h003, 1'b0);
    in_a = 12'h040; in_b = 12'h004; in_acc = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_sum, 13'h011);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(12'h040, 12'h004, 1'b0);
    drain();
    chk("bp_cnt", got_q.size(), 4);
    if (got_q.size() >= 4) begin
      chk("bp_0", got_q[0], 13'h011);
      chk("bp_1", got_q[1], 13'h022);
      chk("bp_2", got_q[2], 13'h033);
      chk("bp_3", got_q[3], 13'h044);
      chk("bp_rate", pop_cyc[3] - pop_cyc[0], 3);
    end

    // clear coincident with the capture of 0x1234
    got_q.delete();
    send(12'hA34, 12'h800, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    drain();
    if (got_q.size() > 0) chk("clr_push", got_q[$], e_clr);
    chk("clr_ovf", out_ovf, 0);
    send(12'h000, 12'h777, 1'b1);
    drain();
    if (got_q.size() > 0) chk("clr_acc", got_q[$], e_accafter);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 12'($urandom);
      in_b      = 12'($urandom);
      in_acc    = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    chk("rand_ovf", out_ovf, m_ovf);

    // Reset mid-stream with a full FIFO and a loaded op register
    out_ready = 1'b0;
    send(12'h800, 12'h800, 1'b0);
    send(12'h001, 12'h001, 1'b0);
    send(12'hFFF, 12'h001, 1'b0);
    chk("pre_rst_ovf", out_ovf, 1);
    chk("pre_rst_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    chk("mid_rst_out_ovf", out_ovf, 0);
    chk("mid_rst_adder_ops", adder_ops, 0);
    exp_q.delete(); got_q.delete();
    m_acc = '0; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_out", out_valid, 0);
    end
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(12'h002, 12'h003, 1'b0);
    drain();
    chk("post_rst_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("post_rst_sum", got_q[0], 13'h005);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
